// File: rtl/sign_mag_pkg.sv
// Shared helpers for the sign-magnitude datapath: field sizing and zero handling.
// Values travel through the helpers zero-extended to a wide word so one set serves any N.
package sign_mag_pkg;

  localparam int SM_W = 64;
  typedef logic [SM_W-1:0] sm_word_t;

  function automatic int sm_sign_idx(input int n);
    return n - 1;
  endfunction

  function automatic int sm_mag_bits(input int n);
    return n - 1;
  endfunction

  function automatic sm_word_t sm_mag_ones(input int n);
    return (sm_word_t'(1) << (n - 1)) - sm_word_t'(1);
  endfunction

  function automatic logic sm_is_zero(input sm_word_t value, input int n);
    return (value & sm_mag_ones(n)) == '0;
  endfunction

  // Any zero magnitude becomes +0 so -0 never reaches the compare or the output.
  function automatic sm_word_t sm_canon(input sm_word_t value, input int n);
    return sm_is_zero(value, n) ? '0 : value;
  endfunction

endpackage

// File: rtl/sign_mag_core.sv
// Combinational sign-magnitude adder with build-time wrap or saturate on overflow.
import sign_mag_pkg::*;

module sign_mag_core #(
  parameter int N        = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] res,
  output logic         ovf
);

  localparam int S = sm_sign_idx(N);
  localparam int M = sm_mag_bits(N);
  localparam logic [M-1:0] MAG_ONES = M'(sm_mag_ones(N));

  logic [N-1:0] w_x;
  logic [N-1:0] w_y;
  logic [M:0]   w_addMag;
  logic [M-1:0] w_mag;
  logic         w_sign;

  // Unlike signs subtract the smaller magnitude from the larger, so only like signs can overflow.
  always_comb begin
    w_x      = N'(sm_canon(sm_word_t'(x), N));
    w_y      = N'(sm_canon(sm_word_t'(y), N));
    w_addMag = {1'b0, w_x[M-1:0]} + {1'b0, w_y[M-1:0]};
    w_mag    = '0;
    w_sign   = 1'b0;
    ovf      = 1'b0;
    if (w_x[S] == w_y[S]) begin
      ovf    = w_addMag[M];
      w_mag  = (w_addMag[M] && SATURATE) ? MAG_ONES : w_addMag[M-1:0];
      w_sign = w_x[S];
    end else if (w_x[M-1:0] >= w_y[M-1:0]) begin
      w_mag  = w_x[M-1:0] - w_y[M-1:0];
      w_sign = w_x[S];
    end else begin
      w_mag  = w_y[M-1:0] - w_x[M-1:0];
      w_sign = w_y[S];
    end
    res = N'(sm_canon(sm_word_t'({w_sign, w_mag}), N));
  end

endmodule

// File: rtl/sign_mag_acc.sv
// Registered sign-magnitude adder/accumulator with valid/ready on both sides.
import sign_mag_pkg::*;

module sign_mag_acc #(
  parameter int N        = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         acc_mode,
  input  logic         clear,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         ovf,
  output logic         ovf_sticky
);

  logic [N-1:0] r_acc;
  logic [N-1:0] r_sum;
  logic         r_ovf;
  logic         r_outValid;
  logic         r_sticky;

  logic [N-1:0] w_x;
  logic [N-1:0] w_res;
  logic         w_ovf;
  logic         w_accept;

  assign in_ready = !r_outValid || out_ready;
  assign w_accept = in_valid && in_ready;
  // A clear arriving with an accumulate starts the new running sum from zero.
  assign w_x      = acc_mode ? (clear ? '0 : r_acc) : a;

  sign_mag_core #(.N(N), .SATURATE(SATURATE)) u_core (
    .x  (w_x),
    .y  (b),
    .res(w_res),
    .ovf(w_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_sum      <= '0;
      r_ovf      <= 1'b0;
      r_outValid <= 1'b0;
      r_sticky   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sum      <= w_res;
        r_ovf      <= w_ovf;
        r_outValid <= 1'b1;
      end else if (out_ready) begin
        r_outValid <= 1'b0;
      end

      if (w_accept && acc_mode) begin
        r_acc <= w_res;
      end else if (clear) begin
        r_acc <= '0;
      end

      // clear restarts the sticky history, keeping only an overflow accepted in the same cycle.
      if (clear) begin
        r_sticky <= w_accept && w_ovf;
      end else if (w_accept) begin
        r_sticky <= r_sticky || w_ovf;
      end
    end
  end

  assign out_valid  = r_outValid;
  assign sum        = r_sum;
  assign ovf        = r_ovf;
  assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_sign_mag_acc.sv
// Directed plus short random bench for sign_mag_acc; wrap and saturate builds run side by side.
module tb_sign_mag_acc;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         acc_mode;
  logic         clear;
  logic         out_ready;

  logic         inReady0, outValid0, ovf0, sticky0;
  logic         inReady1, outValid1, ovf1, sticky1;
  logic [N-1:0] sum0, sum1;

  int total = 0;
  int bad   = 0;

  logic [N:0] q0[$];
  logic [N:0] q1[$];
  logic [N-1:0] mAcc0, mAcc1;
  logic         mSticky0, mSticky1;

  always #5 clk = ~clk;

  sign_mag_acc #(.N(N), .SATURATE(1'b0)) dutWrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(inReady0),
    .a(a), .b(b), .acc_mode(acc_mode), .clear(clear),
    .out_valid(outValid0), .out_ready(out_ready),
    .sum(sum0), .ovf(ovf0), .ovf_sticky(sticky0)
  );

  sign_mag_acc #(.N(N), .SATURATE(1'b1)) dutSat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(inReady1),
    .a(a), .b(b), .acc_mode(acc_mode), .clear(clear),
    .out_valid(outValid1), .out_ready(out_ready),
    .sum(sum1), .ovf(ovf1), .ovf_sticky(sticky1)
  );

  // Integer reference: signed sum, then overflow handling on the absolute value.
  function automatic logic [N:0] modelAdd(input logic [N-1:0] x, input logic [N-1:0] y, input bit sat);
    int vx, vy, s, m;
    logic ov;
    vx = int'(x[N-2:0]);
    vy = int'(y[N-2:0]);
    if (x[N-1]) vx = -vx;
    if (y[N-1]) vy = -vy;
    s  = vx + vy;
    m  = (s < 0) ? -s : s;
    ov = (m > 7);
    if (ov) m = sat ? 7 : (m % 8);
    return {ov, (s < 0) && (m != 0), 3'(m)};
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    q0.delete();
    q1.delete();
    mAcc0 = '0;
    mAcc1 = '0;
    mSticky0 = 1'b0;
    mSticky1 = 1'b0;
  endtask

  // One cycle: drive, check at the negedge, update the model, then cross the posedge.
  task automatic applyStimulus(input bit iv, input logic [N-1:0] ia, input logic [N-1:0] ib,
                               input bit am, input bit cl, input bit orr, input bit rst);
    logic [N:0] r0, r1;
    logic [N-1:0] x0, x1;
    bit expReady, accept;
    in_valid = iv; a = ia; b = ib; acc_mode = am; clear = cl; out_ready = orr; reset = rst;
    @(negedge clk);
    expReady = (q0.size() == 0) || orr;
    checkOutput("in_ready", {7'd0, inReady0}, {7'd0, expReady});
    checkOutput("out_valid", {6'd0, outValid1, outValid0}, {6'd0, q1.size() != 0, q0.size() != 0});
    checkOutput("sticky", {6'd0, sticky1, sticky0}, {6'd0, mSticky1, mSticky0});
    if (q0.size() != 0) begin
      checkOutput("wrap_result", {3'd0, ovf0, sum0}, {3'd0, q0[0]});
      checkOutput("sat_result", {3'd0, ovf1, sum1}, {3'd0, q1[0]});
    end
    if (rst) begin
      modelReset();
    end else begin
      accept = iv && expReady;
      if (q0.size() != 0 && orr) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      x0 = am ? (cl ? '0 : mAcc0) : ia;
      x1 = am ? (cl ? '0 : mAcc1) : ia;
      r0 = modelAdd(x0, ib, 1'b0);
      r1 = modelAdd(x1, ib, 1'b1);
      if (accept) begin
        q0.push_back(r0);
        q1.push_back(r1);
      end
      if (accept && am) begin
        mAcc0 = r0[N-1:0];
        mAcc1 = r1[N-1:0];
      end else if (cl) begin
        mAcc0 = '0;
        mAcc1 = '0;
      end
      if (cl) begin
        mSticky0 = accept && r0[N];
        mSticky1 = accept && r1[N];
      end else if (accept) begin
        mSticky0 = mSticky0 || r0[N];
        mSticky1 = mSticky1 || r1[N];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    acc_mode = 1'b0; clear = 1'b0; out_ready = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus(0, 4'b0000, 4'b0000, 0, 0, 1, 0);
    checkOutput("reset_sum", {4'd0, sum0}, 8'd0);

    applyStimulus(1, 4'b0110, 4'b0110, 0, 0, 1, 0);
    applyStimulus(1, 4'b1110, 4'b1110, 0, 0, 1, 0);
    applyStimulus(1, 4'b0100, 4'b1100, 0, 0, 1, 0);
    applyStimulus(1, 4'b1000, 4'b0000, 0, 0, 1, 0);
    applyStimulus(1, 4'b0010, 4'b1101, 0, 0, 1, 0);
    applyStimulus(1, 4'b0110, 4'b1011, 0, 0, 1, 0);
    applyStimulus(0, 4'b0000, 4'b0000, 0, 0, 1, 0);

    applyStimulus(0, 4'b0000, 4'b0000, 0, 1, 1, 0);
    applyStimulus(1, 4'b0000, 4'b0011, 1, 0, 1, 0);
    applyStimulus(1, 4'b0000, 4'b0011, 1, 0, 1, 0);
    applyStimulus(1, 4'b0000, 4'b0011, 1, 0, 1, 0);
    applyStimulus(1, 4'b0000, 4'b1010, 1, 0, 1, 0);
    applyStimulus(0, 4'b0000, 4'b0000, 0, 0, 1, 0);
    applyStimulus(0, 4'b0000, 4'b0000, 0, 0, 1, 0);

    applyStimulus(1, 4'b0000, 4'b0101, 1, 1, 1, 0);
    applyStimulus(1, 4'b0000, 4'b1010, 1, 1, 1, 0);
    applyStimulus(1, 4'b0000, 4'b0001, 1, 0, 1, 0);
    applyStimulus(0, 4'b0000, 4'b0000, 0, 0, 1, 0);

    applyStimulus(1, 4'b0001, 4'b0001, 0, 0, 0, 0);
    repeat (3) applyStimulus(1, 4'b0010, 4'b0001, 1, 0, 0, 0);
    applyStimulus(1, 4'b0010, 4'b0001, 1, 0, 1, 0);
    applyStimulus(1, 4'b0011, 4'b1001, 0, 0, 1, 0);
    applyStimulus(1, 4'b0000, 4'b0110, 1, 0, 1, 0);
    applyStimulus(1, 4'b0101, 4'b0101, 0, 0, 1, 0);
    applyStimulus(0, 4'b0000, 4'b0000, 0, 0, 1, 0);

    applyStimulus(1, 4'b0000, 4'b0101, 1, 1, 1, 0);
    applyStimulus(1, 4'b0111, 4'b0001, 0, 0, 0, 0);
    applyStimulus(0, 4'b0000, 4'b0000, 0, 0, 0, 1);
    applyStimulus(0, 4'b0000, 4'b0000, 0, 0, 1, 0);
    applyStimulus(1, 4'b0000, 4'b0001, 1, 0, 1, 0);
    applyStimulus(0, 4'b0000, 4'b0000, 0, 0, 1, 0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                    bit'($urandom_range(0, 3) != 0), 1'b0);
    end
    applyStimulus(0, 4'b0000, 4'b0000, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sign_mag_acc.md
Name: sign_mag_acc

Overview:
Registered sign-magnitude adder/accumulator with a valid/ready handshake on both sides.
- Operands and result are N-bit sign-magnitude: MSB is the sign, N-1 bits are the magnitude.
- Two modes, selected per transaction: two-operand add (a+b), or running accumulate (acc+b).
- Overflow handling is a build-time choice of wrap or saturate. A per-result overflow flag and a sticky overflow flag are provided.
- Sits between operand producers and result consumers in the arithmetic datapath.

Parameters:
N, 4, total width including the sign bit (N >= 2)
SATURATE, 0, 0 = wrap the magnitude modulo 2^(N-1) on overflow; 1 = clamp the magnitude to all-ones

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand transaction present
in_ready  output  1  block can accept a transaction this cycle
a  input  N  operand A (ignored when acc_mode=1)
b  input  N  operand B
acc_mode  input  1  1 = result is acc+b, and acc is updated on accept
clear  input  1  synchronous zeroing of acc and ovf_sticky
out_valid  output  1  sum/ovf hold a valid result
out_ready  input  1  consumer accepts the result
sum  output  N  registered sign-magnitude result
ovf  output  1  overflow occurred for the current result
ovf_sticky  output  1  OR of ovf over all accepted results since reset/clear

Behaviour:
- Reset (synchronous, dominates everything): out_valid=0, sum=0, ovf=0, acc=0, ovf_sticky=0. in_ready is 1 in the cycle after reset.
- in_ready = !out_valid || out_ready, combinational. There is no combinational path from in_valid to in_ready.
- Accept = in_valid && in_ready. On accept, sum/ovf register the computed result and out_valid <= 1. Latency is 1 cycle.
- If out_valid && out_ready and there is no accept, out_valid <= 0.
- With out_valid=1 and out_ready=0: sum, ovf and acc hold, and in_ready=0.
- Full throughput: a new transaction can be accepted every cycle while out_ready=1.
- Operand X = acc_mode ? acc : a. Operand Y = b.
- Negative zero (sign=1, magnitude=0) is accepted as +0. The block never outputs negative zero: any zero-magnitude result has sign 0.
- Same signs:
  - mag = |X|+|Y| computed at N bits; overflow when the carry out of the N-1 magnitude bits is 1.
  - Wrap: magnitude = low N-1 bits.
  - Saturate: magnitude = all-ones.
  - Sign = common sign, forced to 0 if the magnitude is 0.
- Different signs:
  - magnitude = larger minus smaller; sign = sign of the larger.
  - Equal magnitudes give +0.
  - Overflow is impossible in this case.
- ovf registers the overflow bit of the result. ovf_sticky <= ovf_sticky | overflow on each accept.
- Accumulator:
  - On an accept with acc_mode=1, acc <= the result, which is the wrapped or saturated value and is identical to sum.
  - On an accept with acc_mode=0, acc is unchanged.
- clear:
  - Without an accept: acc <= 0 and ovf_sticky <= 0.
  - Together with an accepted acc_mode=1 transaction: X is taken as 0, so result = b; acc <= result; ovf_sticky <= overflow of this result (always 0).
  - Together with an accepted acc_mode=0 transaction: acc <= 0; ovf_sticky <= that transaction's overflow.
  - clear never touches out_valid, sum or ovf.
- Reset mid-operation discards any pending result and the accumulator contents.

Decomposition:
- Package sign_mag_pkg:
  - function sm_is_zero(value)
  - function sm_canon, which maps -0 to +0
  - localparam-style helpers for the sign bit index, N-1 and the magnitude all-ones value
- Sub-module sign_mag_core:
  - Combinational; parameters N and SATURATE; inputs x, y; outputs res[N], ovf.
  - Contains all arithmetic.
- sign_mag_acc holds the handshake, the output register, acc and ovf_sticky.

Test Plan:
1. N=4, SATURATE=0, acc_mode=0, a=0110, b=0110 -> next cycle sum=0100, ovf=1, ovf_sticky=1. With SATURATE=1 -> sum=0111, ovf=1. Also a=1110, b=1110 -> sum=1100 (wrap) or 1111 (saturate).
2. a=0100, b=1100 -> sum=0000, ovf=0. a=1000, b=0000 -> sum=0000 (no -0). a=0010, b=1101 -> sum=1011. a=0110, b=1011 -> sum=0011.
3. Accumulate, SATURATE=0: pulse clear, then b=0011 three times with out_ready=1 -> sums 0011, 0110, 0001 (ovf=1 on the third). Then b=1010 -> 1001. ovf_sticky stays 1 until clear. With SATURATE=1, the third sum is 0111, and b=1010 then gives 0101.
4. clear and an acc_mode=1 accept in the same cycle with acc=0101, b=1010 -> sum=1010, acc=1010, ovf_sticky=0.
5. Backpressure: result pending, out_ready=0 for 3 cycles, in_valid=1 -> in_ready=0, sum/acc unchanged. out_ready=1 -> the held input is accepted in that cycle and its result appears the next cycle. Back-to-back transactions give one result per cycle.
6. Reset for 1 cycle while out_valid=1, acc=0101, ovf_sticky=1 -> the next cycle shows out_valid=0, sum=0000, ovf=0, ovf_sticky=0, in_ready=1. A subsequent acc-mode b=0001 gives sum=0001.
